eq_comparator_bist: RTL and testbench
=====================================

# eq_comparator_bist

Built-in self-test sequencer for the equality comparator. It drives every operand pair {a, b} into a comparator under test and samples the comparator's `eq` response. It checks each response against the expected equality and reports pass/fail, an error count and the first failing pair. It sits beside the comparator, drives the comparator's `a`/`b` inputs and reads its `eq` output, so the comparator can be verified on hardware without an external stimulus source.

## Interface
- `WIDTH`, 4, operand width of the comparator under test.

- `clk`  input  1  rising-edge system clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  one-cycle request to begin a sweep.
- `a_out`  output  WIDTH  operand a driven to the comparator (registered).
- `b_out`  output  WIDTH  operand b driven to the comparator (registered).
- `eq_in`  input  1  comparator `eq` response.
- `busy`  output  1  high while sweeping.
- `done`  output  1  high once a sweep completes; held until the next start or reset.
- `pass`  output  1  valid when `done`=1; 1 if no mismatches were found.
- `err_count`  output  2*WIDTH+1  number of mismatching pairs in the last sweep.
- `fail_a`  output  WIDTH  a operand of the first mismatching pair.
- `fail_b`  output  WIDTH  b operand of the first mismatching pair.
- `fail_seen`  output  1  high once `fail_a`/`fail_b` hold a captured pair.

## Operation
- Reset (asynchronous, `rst_n`=0):
  - state=IDLE.
  - All outputs are 0: `a_out`, `b_out`, `busy`, `done`, `pass`, `err_count`, `fail_a`, `fail_b`, `fail_seen`.
- States: IDLE, SWEEP, DONE.
- **IDLE**
  - `start`=1 → SWEEP.
  - On that edge: `a_out`=0, `b_out`=0, `err_count`=0, `fail_seen`=0, `fail_a`/`fail_b`=0, `busy`=1, `done`=0, `pass`=0.
- **SWEEP**, at every edge:
  - expected = (`a_out`==`b_out`). A mismatch is `eq_in` ≠ expected.
  - On a mismatch, `err_count`+1.
  - On a mismatch with `fail_seen`=0: capture `fail_a`=`a_out`, `fail_b`=`b_out`, and set `fail_seen`=1.
  - Not the last pair: {`a_out`,`b_out`} increments as one 2*WIDTH-bit counter, with `b_out` as the low half. Order is (0,0),(0,1)…(0,max),(1,0)…
  - Last pair (`a_out`=`b_out`=all ones): → DONE.
    - `busy`=0, `done`=1.
    - `pass`=1 only if the final `err_count`, including this pair's check, is 0.
    - `a_out`/`b_out` hold all ones.
- `start` during SWEEP is ignored.
- **DONE**
  - All results hold.
  - `start`=1 restarts exactly as from IDLE, clearing the previous results on that edge.
- `err_count` cannot overflow: it has 2*WIDTH+1 bits, and at most 2^(2*WIDTH) pairs can mismatch.

## Timing
- Each pair is presented for exactly one clock and sampled at the closing edge of that cycle. The comparator path from `a_out`/`b_out` to `eq_in` must settle within one clock period.
- Start latency: the first pair (0,0) appears on the edge that samples `start`.
- Sweep length: 2^(2*WIDTH) cycles, i.e. 256 for WIDTH=4.
  - `busy` is high for exactly 2^(2*WIDTH) cycles.
  - `done` rises on the same edge that `busy` falls.
- `fail_a`/`fail_b`/`fail_seen` update on the edge that samples the mismatch.
- `err_count` is final when `done` rises.
- Reset asserted mid-sweep: all outputs clear immediately (asynchronously) and the state returns to IDLE. There is no partial result.
- Reset release: the first edge with `rst_n`=1 may sample `start`.

## Test plan
- **Ideal comparator model** (`eq_in` = `a_out`==`b_out`), single `start` pulse, WIDTH=4 → `busy` high for 256 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_seen`=0, `a_out`=`b_out`=15.
- **`eq_in` stuck at 0** → `err_count`=16, `pass`=0, `fail_a`=0, `fail_b`=0.
- **`eq_in` stuck at 1** → `err_count`=240, `pass`=0, `fail_a`=0, `fail_b`=1.
- **Faulty model that compares only bits [2:0]** → `err_count`=16, `fail_a`=0, `fail_b`=8.
- **Model wrong only at a=10, b=10** → `err_count`=1, `fail_a`=10, `fail_b`=10, `pass`=0.
- **Control sequencing:**
  - `start` pulse at sweep cycle 50 → ignored; `done` still rises 256 cycles after the original start.
  - `rst_n` low at sweep cycle 100 → all outputs become 0 immediately and the block stays in IDLE.
  - `start` in DONE → a new sweep begins and `err_count` clears on that edge.

Source files
------------

// File: rtl/eq_comparator_bist.sv
// ---------------------------------------------------------------------------
// eq_comparator_bist
//
// Built-in self-test sequencer for an equality comparator. After a start
// request it walks every operand pair {a, b} (a as the high half of one
// 2*WIDTH-bit counter, b as the low half), drives the pair onto a_out/b_out
// for exactly one clock and samples the comparator's eq response at the
// closing edge of that clock. Every response is checked against a == b;
// mismatches are counted and the first failing pair is captured.
//
// Parameters
//   WIDTH      operand width of the comparator under test
//
// Ports
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset; clears every output
//   start      one-cycle request to begin a sweep (ignored while sweeping)
//   a_out      operand a driven to the comparator (registered)
//   b_out      operand b driven to the comparator (registered)
//   eq_in      comparator eq response for the pair currently on a_out/b_out
//   busy       high while sweeping (2^(2*WIDTH) cycles)
//   done       high once a sweep completes; held until next start or reset
//   pass       valid while done=1; 1 when no mismatch was found
//   err_count  number of mismatching pairs in the last sweep
//   fail_a     a operand of the first mismatching pair
//   fail_b     b operand of the first mismatching pair
//   fail_seen  high once fail_a/fail_b hold a captured pair
// ---------------------------------------------------------------------------
module eq_comparator_bist #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 eq_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic                 fail_seen
);

    localparam int PAIR_W = 2 * WIDTH;
    localparam int CNT_W  = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // The operand pair lives in one counter so the sweep order falls out of
    // a plain increment: b is the low half and wraps into a.
    logic [PAIR_W-1:0] pair_q;
    logic              start_sweep;
    logic              mismatch;
    logic              last_pair;
    logic [CNT_W-1:0]  err_next;

    // Reference behaviour of a correct comparator for one pair.
    function automatic logic expected_eq(input logic [PAIR_W-1:0] pair);
        return pair[PAIR_W-1:WIDTH] == pair[WIDTH-1:0];
    endfunction

    // Mismatch count cannot overflow: CNT_W bits hold 2^(2*WIDTH) exactly,
    // so a plain add is sufficient.
    function automatic logic [CNT_W-1:0] count_add(input logic [CNT_W-1:0] cnt,
                                                   input logic             inc);
        return cnt + {{(CNT_W-1){1'b0}}, inc};
    endfunction

    assign a_out = pair_q[PAIR_W-1:WIDTH];
    assign b_out = pair_q[WIDTH-1:0];

    // -----------------------------------------------------------------------
    // Control: state register and next-state decode
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_sweep = 1'b0;
        mismatch    = 1'b0;
        last_pair   = &pair_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SWEEP;
                    start_sweep = 1'b1;
                end
            end
            SWEEP: begin
                mismatch = (eq_in != expected_eq(pair_q));
                if (last_pair) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d     = SWEEP;
                    start_sweep = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Includes the response sampled on this edge, so the pass decision on
    // the last pair sees the final count.
    assign err_next = count_add(err_count, mismatch);

    // -----------------------------------------------------------------------
    // Sweep datapath and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_seen <= 1'b0;
        end else if (start_sweep) begin
            // First pair (0,0) is presented on the edge that samples start;
            // previous results are discarded on the same edge.
            pair_q    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_seen <= 1'b0;
        end else if (state_q == SWEEP) begin
            err_count <= err_next;
            if (mismatch && !fail_seen) begin
                fail_a    <= pair_q[PAIR_W-1:WIDTH];
                fail_b    <= pair_q[WIDTH-1:0];
                fail_seen <= 1'b1;
            end
            if (last_pair) begin
                // Operands stay at all-ones once the sweep is over.
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_next == '0);
            end else begin
                pair_q <= pair_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eq_comparator_bist.sv
module tb_eq_comparator_bist;

    localparam int WIDTH    = 4;
    localparam int SWEEP_N  = 256;
    localparam int MAX_WAIT = 400;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             eq_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2*WIDTH:0] err_count;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
    logic             fail_seen;

    // Comparator models placed beside the DUT
    localparam logic [2:0] M_IDEAL = 3'd0;
    localparam logic [2:0] M_ST0   = 3'd1;
    localparam logic [2:0] M_ST1   = 3'd2;
    localparam logic [2:0] M_LOW3  = 3'd3;
    localparam logic [2:0] M_ONE   = 3'd4;
    logic [2:0] mode;

    always_comb begin
        eq_in = 1'b0;
        case (mode)
            M_IDEAL: eq_in = (a_out == b_out);
            M_ST0:   eq_in = 1'b0;
            M_ST1:   eq_in = 1'b1;
            M_LOW3:  eq_in = (a_out[2:0] == b_out[2:0]);
            M_ONE:   eq_in = (a_out == b_out) ^ ((a_out == 4'd10) && (b_out == 4'd10));
            default: eq_in = (a_out == b_out);
        endcase
    end

    eq_comparator_bist #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_out     (a_out),
        .b_out     (b_out),
        .eq_in     (eq_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_a    (fail_a),
        .fail_b    (fail_b),
        .fail_seen (fail_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string   name;
        int      err;
        logic    pass;
        int      fa;
        int      fb;
        logic    fseen;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles and scores each completed sweep
    logic done_prev = 1'b0;
    int   busy_cnt  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, ".busy_cycles"}, busy_cnt, SWEEP_N);
                    check({e.name, ".err_count"}, err_count, e.err);
                    check({e.name, ".pass"}, pass, e.pass);
                    check({e.name, ".fail_seen"}, fail_seen, e.fseen);
                    check({e.name, ".fail_a"}, fail_a, e.fa);
                    check({e.name, ".fail_b"}, fail_b, e.fb);
                    check({e.name, ".a_out"}, a_out, 15);
                    check({e.name, ".b_out"}, b_out, 15);
                    check({e.name, ".busy"}, busy, 0);
                end
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
        end
        done_prev = done;
    end

    // Pulse start, check the start edge, then wait for done (bounded).
    // A second start is pulsed at sweep cycle ignore_at (if >= 0).
    task automatic run_sweep(input string name, input int ignore_at);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, ".start_busy"}, busy, 1);
        check({name, ".start_done"}, done, 0);
        check({name, ".start_err"}, err_count, 0);
        check({name, ".start_pair"}, {a_out, b_out}, 0);
        cyc = 0;
        while (!done && cyc < MAX_WAIT) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == ignore_at);
        end
        start = 1'b0;
        check({name, ".latency"}, cyc, SWEEP_N);
    endtask

    function automatic exp_t mk(input string name, input int err, input logic p,
                                input int fa, input int fb, input logic fs);
        exp_t e;
        e.name = name; e.err = err; e.pass = p; e.fa = fa; e.fb = fb; e.fseen = fs;
        return e;
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = M_IDEAL;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.pass", pass, 0);
        check("rst.err", err_count, 0);
        check("rst.pair", {a_out, b_out}, 0);
        check("rst.fail", {fail_seen, fail_a, fail_b}, 0);
        rst_n = 1'b1;

        mode = M_IDEAL;
        exp_q.push_back(mk("ideal", 0, 1'b1, 0, 0, 1'b0));
        run_sweep("ideal", -1);
        repeat (3) @(posedge clk);
        #1;
        check("ideal.done_hold", done, 1);

        mode = M_ST0;
        exp_q.push_back(mk("stuck0", 16, 1'b0, 0, 0, 1'b1));
        run_sweep("stuck0", -1);

        mode = M_ST1;
        exp_q.push_back(mk("stuck1", 240, 1'b0, 0, 1, 1'b1));
        run_sweep("stuck1", -1);

        mode = M_LOW3;
        exp_q.push_back(mk("low3", 16, 1'b0, 0, 8, 1'b1));
        run_sweep("low3", -1);

        // Extra start at sweep cycle 50 must not disturb the sweep
        mode = M_ONE;
        exp_q.push_back(mk("single", 1, 1'b0, 10, 10, 1'b1));
        run_sweep("single", 50);

        // Restart from DONE clears previous results on the start edge
        mode = M_IDEAL;
        exp_q.push_back(mk("restart", 0, 1'b1, 0, 0, 1'b0));
        run_sweep("restart", -1);

        // Asynchronous reset in the middle of a sweep
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check("midrst.pass", pass, 0);
        check("midrst.err", err_count, 0);
        check("midrst.pair", {a_out, b_out}, 0);
        check("midrst.fail", {fail_seen, fail_a, fail_b}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle.busy", busy, 0);
        check("idle.done", done, 0);
        check("idle.pair", {a_out, b_out}, 0);

        repeat (2) @(posedge clk);
        check("pending_results", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
